// File: rtl/uart_note_decoder.sv
// uart_note_decoder: turns the UART receive byte stream into note pairs
// (uppercase 0x40+n then lowercase 0x60+n) and restart commands ('R').
// It also counts malformed or incomplete sequences in a saturating counter.
module uart_note_decoder #(
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       err_clr,
    output logic [3:0] note1_out,
    output logic [3:0] note2_out,
    output logic       pair_valid,
    output logic       restart,
    output logic       busy,
    output logic [7:0] err_count
);

    // The timer holds (cycles waited - 1), so the largest value it reaches is
    // TIMEOUT_CYCLES-2. Once it reaches that value, the current cycle is
    // k+TIMEOUT_CYCLES-1 relative to the uppercase byte.
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 2);

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_LOW = 1'b1
    } state_t;

    state_t          state_reg;
    logic            vld_q_reg;
    logic [TW-1:0]   timer_reg;
    logic [3:0]      n1_hold_reg;
    logic [3:0]      note1_reg;
    logic [3:0]      note2_reg;
    logic            pair_reg;
    logic            restart_reg;
    logic            busy_reg;
    logic [7:0]      err_reg;

    logic            accept;
    logic            is_up;
    logic            is_lo;
    logic            is_rs;
    logic            is_junk;
    logic            timer_hit;
    logic            err_event;

    assign accept    = rx_valid & ~vld_q_reg;
    assign is_up     = (rx_data[7:4] == 4'h4);
    assign is_lo     = (rx_data[7:4] == 4'h6);
    assign is_rs     = (rx_data == 8'h52);
    assign is_junk   = ~(is_up | is_lo | is_rs);
    assign timer_hit = (timer_reg == TIMER_LAST);

    // Flags a protocol error for the current cycle. An accepted byte always
    // takes priority over the timeout.
    always_comb begin
        err_event = 1'b0;
        if (accept) begin
            if (state_reg == WAIT_LOW)
                err_event = is_up | is_rs | is_junk;
            else
                err_event = is_lo | is_junk;
        end else if (state_reg == WAIT_LOW && timer_hit) begin
            err_event = 1'b1;
        end
    end

    // Runs the pair-assembly state machine, including its registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            vld_q_reg   <= 1'b1;
            timer_reg   <= '0;
            n1_hold_reg <= 4'h0;
            note1_reg   <= 4'h0;
            note2_reg   <= 4'h0;
            pair_reg    <= 1'b0;
            restart_reg <= 1'b0;
            busy_reg    <= 1'b0;
        end else begin
            vld_q_reg   <= rx_valid;
            pair_reg    <= 1'b0;
            restart_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        if (is_up) begin
                            n1_hold_reg <= rx_data[3:0];
                            timer_reg   <= '0;
                            state_reg   <= WAIT_LOW;
                            busy_reg    <= 1'b1;
                        end else if (is_rs) begin
                            restart_reg <= 1'b1;
                        end
                    end
                end
                WAIT_LOW: begin
                    if (accept) begin
                        if (is_lo) begin
                            note1_reg <= n1_hold_reg;
                            note2_reg <= rx_data[3:0];
                            pair_reg  <= 1'b1;
                            state_reg <= IDLE;
                            busy_reg  <= 1'b0;
                        end else if (is_up) begin
                            // A fresh uppercase byte restarts the pair.
                            n1_hold_reg <= rx_data[3:0];
                            timer_reg   <= '0;
                        end else begin
                            restart_reg <= is_rs;
                            state_reg   <= IDLE;
                            busy_reg    <= 1'b0;
                        end
                    end else if (timer_hit) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end else begin
                        timer_reg <= timer_reg + TW'(1);
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    // Counts protocol errors and saturates at 255. A clear wins over an
    // error in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_reg <= 8'h00;
        else if (err_clr)
            err_reg <= 8'h00;
        else if (err_event && err_reg != 8'hFF)
            err_reg <= err_reg + 8'h01;
    end

    assign note1_out  = note1_reg;
    assign note2_out  = note2_reg;
    assign pair_valid = pair_reg;
    assign restart    = restart_reg;
    assign busy       = busy_reg;
    assign err_count  = err_reg;

endmodule

// File: tb/tb_uart_note_decoder.sv
// Testbench for uart_note_decoder: a queue-based scoreboard of expected
// pair/restart pulses with their arrival cycle, plus direct status checks.
module tb_uart_note_decoder;

    localparam int T = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       err_clr = 1'b0;
    logic [3:0] note1_out;
    logic [3:0] note2_out;
    logic       pair_valid;
    logic       restart;
    logic       busy;
    logic [7:0] err_count;

    uart_note_decoder #(.TIMEOUT_CYCLES(T)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .err_clr    (err_clr),
        .note1_out  (note1_out),
        .note2_out  (note2_out),
        .pair_valid (pair_valid),
        .restart    (restart),
        .busy       (busy),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       is_pair;
        bit [3:0] n1;
        bit [3:0] n2;
        int       cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    // Counts posedges so pulses can be checked against their expected cycle.
    always @(posedge clk) cyc <= cyc + 1;

    // Pops the scoreboard whenever the DUT emits a pulse.
    always @(posedge clk) begin
        #1;
        if (pair_valid && restart)
            check("pulse_overlap", 1, 0);
        else if (pair_valid || restart) begin
            if (exp_q.size() == 0) begin
                check(pair_valid ? "unexpected_pair" : "unexpected_restart", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("pulse_kind_pair", int'(pair_valid), int'(e.is_pair));
                check("pulse_cycle", cyc, e.cyc);
                if (e.is_pair) begin
                    check("pair_note1", int'(note1_out), int'(e.n1));
                    check("pair_note2", int'(note2_out), int'(e.n2));
                end
            end
        end
    end

    // Caller is just past a negedge; the byte is accepted at the next posedge.
    task automatic send_byte(input logic [7:0] b, input int hold);
        rx_data  = b;
        rx_valid = 1'b1;
        repeat (hold) @(negedge clk);
        rx_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic expect_pair(input bit [3:0] n1, input bit [3:0] n2);
        exp_t e;
        e.is_pair = 1'b1; e.n1 = n1; e.n2 = n2; e.cyc = cyc + 1;
        exp_q.push_back(e);
    endtask

    task automatic expect_restart();
        exp_t e;
        e.is_pair = 1'b0; e.n1 = 4'h0; e.n2 = 4'h0; e.cyc = cyc + 1;
        exp_q.push_back(e);
    endtask

    task automatic clear_errors();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    // Watchdog so a stuck run still terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rx_valid = 1'b1;   // held high through reset: must not be accepted
        repeat (3) @(negedge clk);
        check("rst_note1", int'(note1_out), 0);
        check("rst_note2", int'(note2_out), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_err", int'(err_count), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("held_no_accept_busy", int'(busy), 0);
        check("held_no_accept_err", int'(err_count), 0);
        rx_valid = 1'b0;
        @(negedge clk);

        // 1: basic pair
        send_byte(8'h43, 1);
        check("t1_busy_between", int'(busy), 1);
        expect_pair(4'd3, 4'd5);
        send_byte(8'h65, 1);
        check("t1_err", int'(err_count), 0);
        check("t1_busy_after", int'(busy), 0);

        // 2: restart in IDLE, then restart discarding a partial pair
        expect_restart();
        send_byte(8'h52, 1);
        check("t2_err0", int'(err_count), 0);
        send_byte(8'h41, 1);
        check("t2_busy_partial", int'(busy), 1);
        expect_restart();
        send_byte(8'h52, 1);
        check("t2_err1", int'(err_count), 1);
        check("t2_busy", int'(busy), 0);
        check("t2_note1_hold", int'(note1_out), 3);
        check("t2_note2_hold", int'(note2_out), 5);

        // 3: timeout boundary (send returns in cycle k+2)
        clear_errors();
        check("t3_clr", int'(err_count), 0);
        send_byte(8'h4F, 1);
        repeat (T - 3) @(negedge clk);
        check("t3_busy_last", int'(busy), 1);
        check("t3_err_before", int'(err_count), 0);
        @(negedge clk);
        check("t3_busy_timeout", int'(busy), 0);
        check("t3_err_timeout", int'(err_count), 1);
        repeat (5) @(negedge clk);
        send_byte(8'h6A, 1);
        check("t3_err_orphan_lo", int'(err_count), 2);

        // 3b: byte in the last allowed cycle beats the timeout
        send_byte(8'h44, 1);
        repeat (T - 3) @(negedge clk);
        expect_pair(4'd4, 4'd8);
        send_byte(8'h68, 1);
        check("t3b_err_no_timeout", int'(err_count), 2);

        // 4: re-latch on a second uppercase, held rx_valid counts once
        clear_errors();
        send_byte(8'h42, 1);
        send_byte(8'h47, 1);
        expect_pair(4'd7, 4'd1);
        send_byte(8'h61, 50);
        check("t4_err", int'(err_count), 1);
        check("t4_note1", int'(note1_out), 7);
        check("t4_note2", int'(note2_out), 1);

        // 5: saturation and clear-wins
        clear_errors();
        for (int i = 0; i < 255; i++) send_byte(8'h00, 1);
        check("t5_err_255", int'(err_count), 255);
        for (int i = 0; i < 45; i++) send_byte(8'h00, 1);
        check("t5_err_sat", int'(err_count), 255);
        err_clr = 1'b1;
        send_byte(8'h00, 1);
        err_clr = 1'b0;
        @(negedge clk);
        check("t5_clr_wins", int'(err_count), 0);

        // 6: async reset mid-pair
        send_byte(8'h00, 1);
        send_byte(8'h45, 1);
        check("t6_busy_pre", int'(busy), 1);
        check("t6_err_pre", int'(err_count), 1);
        rx_data  = 8'h4A;
        rx_valid = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("t6_rst_busy", int'(busy), 0);
        check("t6_rst_err", int'(err_count), 0);
        check("t6_rst_note1", int'(note1_out), 0);
        check("t6_rst_note2", int'(note2_out), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("t6_held_busy", int'(busy), 0);
        check("t6_held_err", int'(err_count), 0);
        rx_valid = 1'b0;
        @(negedge clk);
        send_byte(8'h40, 1);
        expect_pair(4'd0, 4'd0);
        send_byte(8'h60, 1);
        check("t6_err_end", int'(err_count), 0);

        repeat (4) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
